// File: rtl/dm_responder.sv
// Data-memory responder: accepts one byte/half/word load or store, performs it
// against an internal word-wide RAM after LATENCY cycles, and pulses rsp_valid.
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  ready_en_reg;
  logic                  we_reg;
  logic [1:0]            size_reg;
  logic                  signed_reg;
  logic [ADDR_WIDTH+1:0] addr_reg;
  logic [31:0]           wdata_reg;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           ram_q;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept, access_fire, acc_err, wr_en;
  logic [3:0]            be;
  logic [7:0]            wlane [4];
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;

  // Address bits above the RAM are intentionally ignored (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign accept      = req_valid && req_ready;
  assign access_fire = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign word_idx    = addr_reg[ADDR_WIDTH+1:2];

  always_comb begin
    acc_err = 1'b0;
    case (size_reg)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = addr_reg[0];
      2'b10:   acc_err = |addr_reg[1:0];
      default: acc_err = 1'b1;
    endcase
  end

  assign wr_en = access_fire && we_reg && !acc_err;

  // Per-lane byte enables and store data; sb/sh replicate the low byte/half.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size_reg == 2'b10)
                    | ((size_reg == 2'b01) && (addr_reg[1] == LANE[1]))
                    | ((size_reg == 2'b00) && (addr_reg[1:0] == LANE));
      assign wlane[gi] = (size_reg == 2'b00) ? wdata_reg[7:0]
                       : (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8]
                       : wdata_reg[8*gi +: 8];
    end
  endgenerate

  // RAM is not reset; read and write both happen on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (access_fire && !we_reg) begin
      ram_q <= mem[word_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= wlane[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      ready_en_reg <= 1'b0;
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      signed_reg   <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ready_en_reg <= 1'b1;
      if (accept) begin
        we_reg     <= req_we;
        size_reg   <= req_size;
        signed_reg <= req_signed;
        addr_reg   <= req_addr[ADDR_WIDTH+1:0];
        wdata_reg  <= req_wdata;
      end
    end
  end

  always_comb begin
    ld_byte = ram_q[{addr_reg[1:0], 3'b000} +: 8];
    ld_half = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
    case (size_reg)
      2'b00:   ld_ext = {{24{signed_reg & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{signed_reg & ld_half[15]}}, ld_half};
      default: ld_ext = ram_q;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'h0;
    case (state_reg)
      IDLE: begin
        req_ready = ready_en_reg;
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = acc_err;
        rsp_rdata  = (acc_err || we_reg) ? 32'h0 : ld_ext;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 1, 15) share clock and
// reset; expected responses are queued at issue and popped on rsp_valid.
module tb_dm_responder;

  localparam int NDUT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_we     [NDUT];
  logic [1:0]  req_size   [NDUT];
  logic        req_signed [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        rsp_valid  [NDUT];
  logic [31:0] rsp_rdata  [NDUT];
  logic        rsp_err    [NDUT];

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      dm_responder #(
        .ADDR_WIDTH(10),
        .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 15))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_size  (req_size[gi]),
        .req_signed(req_signed[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Called at a negedge; returns at the negedge of the response cycle with
  // req_valid still high so callers can chain requests back to back.
  task automatic run_req(input int k, input string name, input logic we,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   c;
    bit   got;
    bit   ready_bad;
    req_we[k]     = we;
    req_size[k]   = size;
    req_signed[k] = sgn;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_valid[k]  = 1'b1;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sbq.push_back(e);
    c = 0;
    while (!req_ready[k] && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!req_ready[k]) begin
      errors++;
      $display("FAIL %s accept: req_ready stayed 0 for %0d cycles, need 1", name, c);
      void'(sbq.pop_front());
    end else begin
      @(posedge clk);
      got = 1'b0;
      ready_bad = 1'b0;
      c = 0;
      while (!got && c < 40) begin
        @(negedge clk);
        c++;
        if (rsp_valid[k]) got = 1'b1;
        if (req_ready[k]) ready_bad = 1'b1;
      end
      e = sbq.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL %s rsp timeout: no rsp_valid in %0d cycles", name, c);
      end else begin
        checks += 4;
        if (c != lat_of(k) + 1) begin
          errors++;
          $display("FAIL %s latency: got %0d cycles, need %0d", name, c, lat_of(k) + 1);
        end
        if (rsp_rdata[k] !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h, need %h", name, rsp_rdata[k], e.rdata);
        end
        if (rsp_err[k] !== e.err) begin
          errors++;
          $display("FAIL %s err: got %b, need %b", name, rsp_err[k], e.err);
        end
        if (ready_bad) begin
          errors++;
          $display("FAIL %s ready_busy: req_ready got 1 between accept and rsp, need 0", name);
        end
      end
    end
    $display("txn dut%0d %s we=%b size=%b addr=%h wdata=%h rdata=%h err=%b", k, name,
             we, size, addr, wdata, rsp_rdata[k], rsp_err[k]);
  endtask

  // Drop req_valid in the response cycle and confirm a single pulse.
  task automatic end_stream(input int k, input string name);
    req_valid[k] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rsp_valid[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s single_pulse: rsp_valid got %b after rsp, need 0", name, rsp_valid[k]);
    end
    if (req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after: req_ready got %b, need 1", name, req_ready[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b10;
      req_signed[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL reset ready: got %b, need 0", req_ready[0]); end
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b, need 0", rsp_valid[0]); end
    if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL reset rdata: got %h, need 0", rsp_rdata[0]); end
    if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL reset err: got %b, need 0", rsp_err[0]); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL release ready_pre_clk: got %b, need 0", req_ready[0]); end
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL release ready: got %b, need 1", req_ready[0]); end
    $display("txn reset done");
  endtask

  task automatic test_word();
    run_req(0, "sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run_req(0, "lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    end_stream(0, "word");
  endtask

  task automatic test_byte_lanes();
    run_req(0, "sb_13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 32'h0, 1'b0);
    run_req(0, "lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
    run_req(0, "lb_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
    run_req(0, "lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000A5, 1'b0);
    run_req(0, "lh_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFA5AD, 1'b0);
    run_req(0, "lhu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    run_req(0, "lb_10",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    run_req(0, "lbu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000BE, 1'b0);
    end_stream(0, "lanes");
  endtask

  task automatic test_misalign();
    run_req(0, "lw_12",    1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    run_req(0, "sh_11",    1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
    run_req(0, "rsv_ld10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    run_req(0, "rsv_st10", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    run_req(0, "lw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0);
    end_stream(0, "misalign");
  endtask

  task automatic test_wrap();
    run_req(0, "sw_1010", 1'b1, 2'b10, 1'b0, 32'h00001010, 32'h12345678, 32'h0, 1'b0);
    run_req(0, "lw_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
    run_req(0, "lw_hi",   1'b0, 2'b10, 1'b0, 32'hFFFFF010, 32'h0, 32'h12345678, 1'b0);
    end_stream(0, "wrap");
  endtask

  task automatic test_reset_midop();
    bit pulse_seen;
    run_req(0, "sw_20_pre", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, 32'h0, 1'b0);
    end_stream(0, "pre");
    req_we[0] = 1'b1; req_size[0] = 2'b10; req_signed[0] = 1'b0;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h55AA55AA; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL midop ready_in_reset: got %b, need 0", req_ready[0]); end
    pulse_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[0]) pulse_seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL midop ready_after: got %b, need 1", req_ready[0]); end
    repeat (4) begin
      if (rsp_valid[0]) pulse_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (pulse_seen) begin errors++; $display("FAIL midop pulse: rsp_valid got 1 after abort, need 0"); end
    $display("txn dut0 midop_abort sw addr=00000020 wdata=55aa55aa pulse=%b", pulse_seen);
    run_req(0, "lw_20_post", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);
    end_stream(0, "post");
  endtask

  task automatic test_latency_sweep(input int k);
    run_req(k, "sw_40",  1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    run_req(k, "sh_42",  1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234, 32'h0, 1'b0);
    run_req(k, "lw_40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234F00D, 1'b0);
    run_req(k, "lb_41",  1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'hFFFFFFF0, 1'b0);
    run_req(k, "lhu_42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00001234, 1'b0);
    end_stream(k, "sweep");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_misalign();
    test_wrap();
    test_reset_midop();
    test_latency_sweep(1);
    test_latency_sweep(2);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, need 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
